lsu_sequencer: RTL and testbench
================================

Name: lsu_sequencer

Overview:
- Multi-cycle load/store sequencer between the core's memory stage and the data-memory port.
- Accepts one load or store per transaction, keyed by RV32I func3.
- Generates word-aligned address, byte strobes and lane-replicated write data; extracts and sign/zero-extends load data.
- Detects misalignment and illegal func3; aborts stalled memory accesses via a timeout.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in ISSUE+WAIT before abort; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  core requests an access
- req_ready  out  1  sequencer can accept (IDLE only)
- req_is_store  in  1  1 = store, 0 = load
- req_func3  in  3  RV32I width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-justified
- busy  out  1  state != IDLE; core stalls on this
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores and errors)
- resp_err  out  2  00 ok, 01 misaligned, 10 illegal func3, 11 timeout
- mem_req  out  1  memory request, held until mem_gnt
- mem_we  out  1  write request
- mem_addr  out  32  {req_addr[31:2],2'b00}
- mem_wstrb  out  4  byte enables (0000 on loads)
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  read data valid / write ack
- mem_rdata  in  32  read word

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. req_ready = (state==IDLE); busy = !req_ready.
- Reset (async, any state): state IDLE, timeout counter 0, all captured registers 0. All outputs 0 except req_ready=1.
- IDLE, req_valid=1: capture is_store, func3, addr, wdata; clear counter.
  - Error checked on the captured values → RESP with resp_err set, no memory access.
  - Otherwise → ISSUE.
- Legal func3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else → err 10.
- Misaligned → err 01: H with addr[0]=1; W with addr[1:0]!=0. Illegal func3 takes priority over misaligned.
- ISSUE: mem_req=1, with mem_we/mem_addr/mem_wstrb/mem_wdata stable from captured values until mem_gnt. mem_gnt → WAIT. mem_rvalid is ignored in ISSUE (memory guarantees rvalid ≥1 cycle after gnt).
- WAIT: mem_req=0. On mem_rvalid: register the extended load result (stores: 0) and go to RESP with err 00.
- Timeout:
  - Counter increments every cycle in ISSUE and WAIT.
  - When the counter reaches TIMEOUT_CYCLES-1 in a cycle with no mem_rvalid → RESP, err 11, mem_req dropped.
  - mem_rvalid in the same cycle as the timeout: rvalid wins (err 00).
  - Counter saturates; inactive when TIMEOUT_CYCLES=0.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata/resp_err are valid only while resp_valid=1; they hold their value otherwise.
- Stray mem_rvalid in IDLE/RESP (e.g. late after a timeout): ignored, no state change.
- Store strobes (off = addr[1:0]):
  - SB: 0001<<off
  - SH: 0011<<off
  - SW: 1111
- Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
- Load extract: shifted = mem_rdata >> (8*off). LB/LH sign-extend bit 7/15 of shifted; LBU/LHU zero-extend; LW passthrough.
- Latency, zero-wait memory (gnt in first ISSUE cycle, rvalid next cycle): accept at cycle 0, mem_req cycle 1, rvalid cycle 2, resp_valid cycle 3.
- Latency, error path: resp_valid at cycle 1.
- Back-to-back: next request accepted in the cycle after RESP.

Test Plan:
- LW addr 0x100, gnt immediately, rvalid next cycle with rdata 0xDEADBEEF → mem_addr 0x100, wstrb 0000, resp_valid at cycle 3, rdata 0xDEADBEEF, err 00.
- LB addr 0x203, rdata 0x80FF_1234 → rdata 0xFFFFFF80. LBU same → 0x00000080. LH addr 0x202 → 0xFFFF80FF.
- SB addr 0x101, wdata 0x000000AB → mem_we 1, mem_addr 0x100, wstrb 0010, wdata 0xABABABAB. SH addr 0x102 → wstrb 1100.
- SH addr 0x101 → err 01, resp_valid at cycle 1, mem_req never asserted. Store with func3 100 → err 10.
- TIMEOUT_CYCLES=4, gnt never asserted → mem_req high for 4 cycles, then err 11. Later stray rvalid in IDLE → no resp_valid.
- Assert rst while in WAIT → state IDLE immediately (async): mem_req 0, resp_valid 0, req_ready 1. A fresh LW then completes normally.

Source files
------------

// File: rtl/lsu_sequencer_if.sv
// Core-side request/response and data-memory port bundle for lsu_sequencer.
// slave = the sequencer's view; master = the core/memory environment's view.
interface lsu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_is_store, req_func3, req_addr, req_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, busy, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport master (
    output req_valid, req_is_store, req_func3, req_addr, req_wdata,
           mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, busy, resp_valid, resp_rdata, resp_err,
           mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/lsu_sequencer.sv
// Multi-cycle RV32I load/store sequencer: one access per transaction, with
// alignment/func3 checking, lane steering, load extension and a stall timeout.
module lsu_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic            clk,
  input logic            rst,
  lsu_sequencer_if.slave bus
);
  localparam int unsigned CW   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int unsigned TMAX = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic          is_store_q, is_store_d;
  logic [2:0]    func3_q, func3_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_ready_q, req_ready_d;
  logic          mem_req_q, mem_req_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic [1:0]    resp_err_q, resp_err_d;

  logic [1:0]    chk;
  logic          timeout_hit;
  logic [1:0]    off;
  logic [3:0]    wstrb;
  logic [31:0]   wlane;

  // Illegal func3 outranks misalignment.
  function automatic logic [1:0] access_err(logic st, logic [2:0] f3, logic [1:0] a);
    logic legal;
    legal = st ? (f3 inside {3'b000, 3'b001, 3'b010})
               : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    if (!legal)                        return 2'b10;
    if (f3[1:0] == 2'b01 && a[0])      return 2'b01;
    if (f3[1:0] == 2'b10 && a != 2'b0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] load_ext(logic [2:0] f3, logic [1:0] o, logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {o, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b010:  return d;
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  assign chk         = access_err(bus.req_is_store, bus.req_func3, bus.req_addr[1:0]);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TMAX));
  assign off         = addr_q[1:0];

  always_comb begin
    wstrb = 4'b1111;
    wlane = wdata_q;
    case (func3_q[1:0])
      2'b00: begin wstrb = 4'b0001 << off; wlane = {4{wdata_q[7:0]}};  end
      2'b01: begin wstrb = 4'b0011 << off; wlane = {2{wdata_q[15:0]}}; end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    func3_d      = func3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        is_store_d = bus.req_is_store;
        func3_d    = bus.req_func3;
        addr_d     = bus.req_addr;
        wdata_d    = bus.req_wdata;
        cnt_d      = '0;
        if (chk != 2'b00) begin
          state_d      = S_RESP;
          resp_err_d   = chk;
          resp_rdata_d = 32'h0;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        // Abort wins over a same-cycle grant; any later rvalid lands in IDLE/RESP.
        if (timeout_hit) begin
          state_d      = S_RESP;
          resp_err_d   = 2'b11;
          resp_rdata_d = 32'h0;
        end else if (bus.mem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (bus.mem_rvalid) begin
          state_d      = S_RESP;
          resp_err_d   = 2'b00;
          resp_rdata_d = is_store_q ? 32'h0 : load_ext(func3_q, off, bus.mem_rdata);
        end else if (timeout_hit) begin
          state_d      = S_RESP;
          resp_err_d   = 2'b11;
          resp_rdata_d = 32'h0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d  = (state_d == S_IDLE);
    mem_req_d    = (state_d == S_ISSUE);
    resp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      is_store_q   <= 1'b0;
      func3_q      <= 3'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      mem_req_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      func3_q      <= func3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      mem_req_q    <= mem_req_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.busy       = !req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = is_store_q;
  assign bus.mem_addr   = {addr_q[31:2], 2'b00};
  assign bus.mem_wstrb  = is_store_q ? wstrb : 4'b0000;
  assign bus.mem_wdata  = is_store_q ? wlane : 32'h0;
endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer: the driver pushes expected responses into a
// queue and a monitor pops/compares them whenever resp_valid is seen.
module tb_lsu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          at;
  } exp_t;
  exp_t exp_q[$];

  lsu_sequencer_if bus();
  lsu_sequencer #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every resp_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: resp_valid with empty scoreboard (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_err", {30'h0, bus.resp_err}, {30'h0, e.err});
        chk("resp_cycle", cyc, e.at);
      end
    end
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int c0);
    @(negedge clk);
    chk("req_ready", {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid = 1'b1; bus.req_is_store = st; bus.req_func3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    c0 = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Zero-wait memory transaction with expected port fields and response.
  task automatic mem_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input logic [3:0] e_strb, input logic [31:0] e_wdata,
                         input logic [31:0] e_rdata);
    int c0;
    exp_t e;
    issue(st, f3, a, wd, c0);
    e.rdata = e_rdata; e.err = 2'b00; e.at = c0 + 3;
    exp_q.push_back(e);
    chk("mem_req", {31'h0, bus.mem_req}, 32'h1);
    chk("mem_we", {31'h0, bus.mem_we}, {31'h0, st});
    chk("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
    chk("mem_wstrb", {28'h0, bus.mem_wstrb}, {28'h0, e_strb});
    if (st) chk("mem_wdata", bus.mem_wdata, e_wdata);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    chk("mem_req_drop", {31'h0, bus.mem_req}, 32'h0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = rd;
    @(negedge clk);
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    @(negedge clk);
    chk("idle_after_resp", {31'h0, bus.req_ready}, 32'h1);
  endtask

  task automatic err_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [1:0] e_err);
    int c0;
    exp_t e;
    issue(st, f3, a, 32'h0, c0);
    e.rdata = 32'h0; e.err = e_err; e.at = c0 + 1;
    exp_q.push_back(e);
    chk("err_no_mem_req", {31'h0, bus.mem_req}, 32'h0);
    @(negedge clk);
    chk("err_no_mem_req2", {31'h0, bus.mem_req}, 32'h0);
  endtask

  initial begin
    int c0, nreq;
    exp_t e;
    bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_func3 = 3'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    chk("rst_resp", {29'h0, bus.resp_valid, bus.resp_err}, 32'h0);
    chk("rst_mem_bus", {bus.mem_addr[31:5], bus.mem_we, bus.mem_wstrb} | bus.mem_wdata, 32'h0);
    rst = 1'b0;

    mem_txn(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 4'b0000, 0, 32'hDEADBEEF);
    mem_txn(0, 3'b000, 32'h203, 0, 32'h80FF1234, 4'b0000, 0, 32'hFFFFFF80);
    mem_txn(0, 3'b100, 32'h203, 0, 32'h80FF1234, 4'b0000, 0, 32'h00000080);
    mem_txn(0, 3'b001, 32'h202, 0, 32'h80FF1234, 4'b0000, 0, 32'hFFFF80FF);
    mem_txn(0, 3'b101, 32'h202, 0, 32'h80FF1234, 4'b0000, 0, 32'h000080FF);
    mem_txn(0, 3'b000, 32'h200, 0, 32'h80FF1234, 4'b0000, 0, 32'h00000034);
    mem_txn(1, 3'b000, 32'h101, 32'h000000AB, 32'hFFFFFFFF, 4'b0010, 32'hABABABAB, 0);
    mem_txn(1, 3'b001, 32'h102, 32'h00001234, 32'hFFFFFFFF, 4'b1100, 32'h12341234, 0);
    mem_txn(1, 3'b010, 32'h104, 32'hCAFEF00D, 32'hFFFFFFFF, 4'b1111, 32'hCAFEF00D, 0);

    err_txn(1, 3'b001, 32'h101, 2'b01);
    err_txn(1, 3'b100, 32'h100, 2'b10);
    err_txn(0, 3'b011, 32'h100, 2'b10);
    err_txn(0, 3'b010, 32'h102, 2'b01);
    err_txn(0, 3'b111, 32'h003, 2'b10);

    // Timeout with TIMEOUT_CYCLES=4: grant never arrives.
    issue(0, 3'b010, 32'h300, 0, c0);
    e.rdata = 32'h0; e.err = 2'b11; e.at = c0 + 5;
    exp_q.push_back(e);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.resp_valid) break;
      if (bus.mem_req) nreq++;
      @(negedge clk);
    end
    chk("timeout_mem_req_cycles", nreq, 4);
    @(negedge clk);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h12345678;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    chk("stray_rvalid_idle", {30'h0, bus.req_ready, bus.resp_valid}, 32'h2);

    // Async reset while waiting for read data.
    issue(0, 3'b010, 32'h400, 0, c0);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_req", {31'h0, bus.mem_req}, 32'h0);
    chk("arst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("arst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    mem_txn(0, 3'b010, 32'h500, 0, 32'h0BADF00D, 4'b0000, 0, 32'h0BADF00D);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
